// File: rtl/wide_alu_seq.sv
// wide_alu_seq: 16-bit operations sequenced over an external 8-bit ALU in
// two byte passes. The FSM latches the request, feeds one byte pair per
// pass, chains the shift/carry between passes and publishes the merged
// result, carry and zero flag when it enters FIN.
module wide_alu_seq (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        START,
   input  logic [2:0]  OP,
   input  logic [15:0] A,
   input  logic [15:0] B,
   output logic [7:0]  ALU_A,
   output logic [7:0]  ALU_B,
   output logic [2:0]  ALU_OP,
   output logic        ALU_SC_IN,
   input  logic [7:0]  ALU_OUT,
   input  logic        ALU_SC_OUT,
   output logic [15:0] RESULT,
   output logic        SC_OUT,
   output logic        ZERO,
   output logic        BUSY,
   output logic        DONE
);

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_LSH = 3'd1;
   localparam logic [2:0] OP_RSH = 3'd2;
   localparam logic [2:0] OP_XOR = 3'd3;
   localparam logic [2:0] OP_AND = 3'd4;
   localparam logic [2:0] OP_SUB = 3'd5;

   typedef enum logic [1:0] {IDLE, PASS0, PASS1, FIN} state_t;

   state_t      state;
   logic [2:0]  op_q;
   logic [15:0] a_q;
   logic [15:0] b_q;
   logic [15:0] res_q;     // byte-wise partial result built across passes
   logic        carry_q;   // shift/carry handed from PASS0 to PASS1
   logic        accept;
   logic        rsh_q;
   logic        illegal_q;
   logic [15:0] full_res;

   // A new request is only taken when no pass is in flight.
   assign accept    = START && ((state == IDLE) || (state == FIN));
   // Right shift must start at the high byte so the carry moves downward.
   assign rsh_q     = (op_q == OP_RSH);
   assign illegal_q = (op_q > OP_SUB);

   // Drive the byte ALU only during the two passes; idle it at zero otherwise.
   always_comb begin
      ALU_A     = '0;
      ALU_B     = '0;
      ALU_OP    = '0;
      ALU_SC_IN = 1'b0;
      case (state)
         PASS0: begin
            ALU_OP    = op_q;
            ALU_A     = rsh_q ? a_q[15:8] : a_q[7:0];
            ALU_B     = rsh_q ? b_q[15:8] : b_q[7:0];
            // Two's-complement subtract: the low byte gets the +1 carry-in.
            ALU_SC_IN = (op_q == OP_SUB);
         end
         PASS1: begin
            ALU_OP    = op_q;
            ALU_A     = rsh_q ? a_q[7:0] : a_q[15:8];
            ALU_B     = rsh_q ? b_q[7:0] : b_q[15:8];
            ALU_SC_IN = carry_q;
         end
         default: ;
      endcase
   end

   // Merge the PASS1 byte with the stored PASS0 byte; illegal ops read as zero.
   always_comb begin
      if (illegal_q)
         full_res = '0;
      else if (rsh_q)
         full_res = {res_q[15:8], ALU_OUT};
      else
         full_res = {ALU_OUT, res_q[7:0]};
   end

   // Sequencer: latch request, run two passes, publish result in FIN.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state   <= IDLE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         RESULT  <= '0;
         SC_OUT  <= 1'b0;
         ZERO    <= 1'b0;
         BUSY    <= 1'b0;
         DONE    <= 1'b0;
      end else begin
         case (state)
            IDLE, FIN: begin
               DONE <= 1'b0;
               if (accept) begin
                  op_q  <= OP;
                  a_q   <= A;
                  b_q   <= B;
                  state <= PASS0;
                  BUSY  <= 1'b1;
               end else begin
                  state <= IDLE;
                  BUSY  <= 1'b0;
               end
            end
            PASS0: begin
               if (rsh_q)
                  res_q[15:8] <= ALU_OUT;
               else
                  res_q[7:0]  <= ALU_OUT;
               carry_q <= ALU_SC_OUT;
               state   <= PASS1;
            end
            PASS1: begin
               if (rsh_q)
                  res_q[7:0]  <= ALU_OUT;
               else
                  res_q[15:8] <= ALU_OUT;
               RESULT <= full_res;
               SC_OUT <= illegal_q ? 1'b0 : ALU_SC_OUT;
               ZERO   <= (full_res == 16'h0000);
               state  <= FIN;
               BUSY   <= 1'b0;
               DONE   <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wide_alu_seq.sv
// Bench for wide_alu_seq: an 8-bit ALU model closes the loop, a 16-bit
// arithmetic reference predicts results, and directed sequences cover
// ignored START, back-to-back requests, mid-operation reset and illegal ops.
module tb_wide_alu_seq;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        START = 1'b0;
   logic [2:0]  OP = '0;
   logic [15:0] A = '0;
   logic [15:0] B = '0;
   logic [7:0]  ALU_A, ALU_B, ALU_OUT;
   logic [2:0]  ALU_OP;
   logic        ALU_SC_IN, ALU_SC_OUT;
   logic [15:0] RESULT;
   logic        SC_OUT, ZERO, BUSY, DONE;

   int passed = 0;
   int total  = 0;
   logic [15:0] hold_res = '0;
   logic        hold_sc  = 1'b0;
   logic        hold_z   = 1'b0;

   wide_alu_seq dut (
      .CLK(CLK), .RESET(RESET), .START(START), .OP(OP), .A(A), .B(B),
      .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_OP(ALU_OP), .ALU_SC_IN(ALU_SC_IN),
      .ALU_OUT(ALU_OUT), .ALU_SC_OUT(ALU_SC_OUT),
      .RESULT(RESULT), .SC_OUT(SC_OUT), .ZERO(ZERO), .BUSY(BUSY), .DONE(DONE)
   );

   always #5 CLK = ~CLK;

   // External 8-bit ALU; illegal opcodes return junk so forcing is visible.
   logic [8:0] alu_sum;
   always_comb begin
      alu_sum = '0;
      case (ALU_OP)
         3'd0: alu_sum = {1'b0, ALU_A} + {1'b0, ALU_B} + {8'd0, ALU_SC_IN};
         3'd5: alu_sum = {1'b0, ALU_A} + {1'b0, ~ALU_B} + {8'd0, ALU_SC_IN};
         3'd1: alu_sum = {ALU_A, ALU_SC_IN};
         3'd2: alu_sum = {ALU_A[0], ALU_SC_IN, ALU_A[7:1]};
         3'd3: alu_sum = {1'b0, ALU_A ^ ALU_B};
         3'd4: alu_sum = {1'b0, ALU_A & ALU_B};
         default: alu_sum = 9'h1A5;
      endcase
   end
   assign ALU_OUT    = alu_sum[7:0];
   assign ALU_SC_OUT = alu_sum[8];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Whole-word reference model.
   task automatic model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] res, output logic sc, output logic z);
      logic [16:0] t;
      t = '0;
      case (op)
         3'd0: t = {1'b0, a} + {1'b0, b};
         3'd5: t = {1'b0, a} - {1'b0, b} + 17'h10000;
         3'd1: t = {a, 1'b0};
         3'd2: t = {a[0], a >> 1};
         3'd3: t = {1'b0, a ^ b};
         3'd4: t = {1'b0, a & b};
         default: t = '0;
      endcase
      res = t[15:0];
      sc  = t[16];
      z   = (res == 16'h0000);
   endtask

   // One full operation from IDLE with cycle-accurate checks.
   task automatic run_op(input string nm, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] er,
                         input logic esc, input logic ez);
      @(negedge CLK);
      START = 1'b1; OP = op; A = a; B = b;
      @(posedge CLK); #1;
      START = 1'b0;
      chk({nm, " busy t+1"}, {15'd0, BUSY}, 16'd1);
      chk({nm, " done t+1"}, {15'd0, DONE}, 16'd0);
      @(posedge CLK); #1;
      chk({nm, " busy t+2"}, {15'd0, BUSY}, 16'd1);
      chk({nm, " hold t+2"}, RESULT, hold_res);
      @(posedge CLK); #1;
      chk({nm, " done t+3"}, {15'd0, DONE}, 16'd1);
      chk({nm, " busy t+3"}, {15'd0, BUSY}, 16'd0);
      chk({nm, " result"}, RESULT, er);
      chk({nm, " sc"}, {15'd0, SC_OUT}, {15'd0, esc});
      chk({nm, " zero"}, {15'd0, ZERO}, {15'd0, ez});
      chk({nm, " alu idle"}, {ALU_A, ALU_OP, ALU_SC_IN, 4'd0}, 16'd0);
      @(posedge CLK); #1;
      chk({nm, " done drop"}, {15'd0, DONE}, 16'd0);
      hold_res = er; hold_sc = esc; hold_z = ez;
   endtask

   typedef struct {
      string       nm;
      logic [2:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
      logic        sc;
      logic        z;
   } vec_t;

   vec_t vecs[10];

   initial begin
      logic [15:0] r, r2;
      logic        s, z;
      vecs[0] = '{"add_ff_1",   3'd0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0};
      vecs[1] = '{"add_wrap",   3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1};
      vecs[2] = '{"sub_borrow", 3'd5, 16'h0100, 16'h0001, 16'h00FF, 1'b1, 1'b0};
      vecs[3] = '{"sub_neg",    3'd5, 16'h0001, 16'h0002, 16'hFFFF, 1'b0, 1'b0};
      vecs[4] = '{"lsh",        3'd1, 16'h8080, 16'h0000, 16'h0100, 1'b1, 1'b0};
      vecs[5] = '{"rsh",        3'd2, 16'h0101, 16'h0000, 16'h0080, 1'b1, 1'b0};
      vecs[6] = '{"xor",        3'd3, 16'hF0F0, 16'h0FF0, 16'hFF00, 1'b0, 1'b0};
      vecs[7] = '{"and_zero",   3'd4, 16'h00FF, 16'hFF00, 16'h0000, 1'b0, 1'b1};
      vecs[8] = '{"op7",        3'd7, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b1};
      vecs[9] = '{"op6",        3'd6, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b1};

      // Reset state
      #1;
      chk("rst result", RESULT, 16'd0);
      chk("rst flags", {11'd0, SC_OUT, ZERO, BUSY, DONE, 1'b0}, 16'd0);
      chk("rst alu", {ALU_A, ALU_OP, ALU_SC_IN, 4'd0}, 16'd0);
      chk("rst alu_b", {8'd0, ALU_B}, 16'd0);
      @(negedge CLK); @(negedge CLK);
      RESET = 1'b0;
      @(posedge CLK); #1;
      chk("idle busy", {15'd0, BUSY}, 16'd0);

      // Directed vectors
      foreach (vecs[i])
         run_op(vecs[i].nm, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].sc, vecs[i].z);

      // START during PASS0 with different operands is ignored
      @(negedge CLK);
      START = 1'b1; OP = 3'd0; A = 16'h1234; B = 16'h1111;
      @(posedge CLK);
      @(negedge CLK);
      A = 16'hFFFF; B = 16'hFFFF; OP = 3'd5;
      @(posedge CLK);
      @(negedge CLK);
      START = 1'b0;
      @(posedge CLK); #1;
      chk("ign done", {15'd0, DONE}, 16'd1);
      chk("ign result", RESULT, 16'h2345);
      @(posedge CLK); #1;
      chk("ign idle", {14'd0, BUSY, DONE}, 16'd0);
      hold_res = 16'h2345;

      // START held into FIN: back-to-back, second DONE three cycles later
      @(negedge CLK);
      START = 1'b1; OP = 3'd3; A = 16'hA5A5; B = 16'hFFFF;
      @(posedge CLK);
      @(negedge CLK);
      OP = 3'd0; A = 16'h7FFF; B = 16'h0001;
      @(posedge CLK); @(posedge CLK); #1;
      chk("b2b done1", {15'd0, DONE}, 16'd1);
      chk("b2b res1", RESULT, 16'h5A5A);
      @(posedge CLK); #1;
      START = 1'b0;
      chk("b2b pass0 busy", {14'd0, BUSY, DONE}, 16'd2);
      chk("b2b hold", RESULT, 16'h5A5A);
      @(posedge CLK); #1;
      chk("b2b pass1", {14'd0, BUSY, DONE}, 16'd2);
      @(posedge CLK); #1;
      chk("b2b done2", {15'd0, DONE}, 16'd1);
      chk("b2b res2", RESULT, 16'h8000);
      @(posedge CLK); #1;
      hold_res = 16'h8000;

      // Reset in PASS1 aborts without DONE
      @(negedge CLK);
      START = 1'b1; OP = 3'd0; A = 16'h0001; B = 16'h0001;
      @(posedge CLK); #1;
      START = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      RESET = 1'b1;
      #1;
      chk("rst mid busy", {15'd0, BUSY}, 16'd0);
      chk("rst mid result", RESULT, 16'd0);
      chk("rst mid done", {15'd0, DONE}, 16'd0);
      @(negedge CLK);
      RESET = 1'b0;
      begin
         int seen;
         seen = 0;
         for (int k = 0; k < 5; k++) begin
            @(posedge CLK); #1;
            if (DONE || BUSY) seen++;
         end
         chk("rst no done", seen[15:0], 16'd0);
      end
      hold_res = 16'h0000;

      // Random operations against the word-level model
      for (int n = 0; n < 40; n++) begin
         logic [2:0]  op;
         logic [15:0] a, b;
         op = 3'($urandom_range(0, 7));
         a  = 16'($urandom);
         b  = (n % 5 == 0) ? a : 16'($urandom);
         model(op, a, b, r, s, z);
         run_op($sformatf("rnd%0d", n), op, a, b, r, s, z);
      end

      // Spot-check model agreement on one hand-worked case
      model(3'd5, 16'h0100, 16'h0001, r2, s, z);
      run_op("model_sub", 3'd5, 16'h0100, 16'h0001, r2, s, z);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/wide_alu_seq.md
WIDE_ALU_SEQ -- requirements
Module: wide_alu_seq

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset: CLK, RESET.
REQ-002 The block SHALL have these ports, one per line:
- CLK  in  1  system clock, rising edge
- RESET  in  1  asynchronous active-high reset
- START  in  1  request a 16-bit operation
- OP  in  3  operation code: 0 ADD, 1 LSH, 2 RSH, 3 XOR, 4 AND, 5 SUB, 6-7 illegal
- A  in  16  operand A
- B  in  16  operand B
- ALU_A  out  8  byte of A driven to the 8-bit ALU
- ALU_B  out  8  byte of B driven to the 8-bit ALU
- ALU_OP  out  3  opcode driven to the ALU
- ALU_SC_IN  out  1  shift/carry input to the ALU
- ALU_OUT  in  8  ALU result byte
- ALU_SC_OUT  in  1  ALU shift/carry output
- RESULT  out  16  registered 16-bit result
- SC_OUT  out  1  registered final shift/carry
- ZERO  out  1  registered flag, high when RESULT == 0
- BUSY  out  1  high while an operation is in progress
- DONE  out  1  one-cycle completion pulse
REQ-003 The ALU contract SHALL be combinational, with results valid in the same cycle:
- ADD: {SC_OUT,OUT} = A+B+SC_IN
- SUB: {SC_OUT,OUT} = A+~B+SC_IN
- LSH: {SC_OUT,OUT} = {A,SC_IN}
- RSH: OUT = {SC_IN,A[7:1]}, SC_OUT = A[0]
- XOR/AND: bitwise, SC_OUT = 0

Function
REQ-004 The FSM SHALL have four states: IDLE, PASS0, PASS1, FIN.
REQ-005 START SHALL be accepted only in IDLE or FIN. On acceptance, A, B and OP are latched and the next state is PASS0.
REQ-006 START SHALL be ignored in PASS0 and PASS1. The latched operands SHALL remain unchanged.
REQ-007 The state transitions SHALL be PASS0 -> PASS1 -> FIN. FIN -> IDLE unless START is accepted in FIN.
REQ-008 Pass ordering SHALL depend on the operation:
- ADD, SUB, LSH, XOR, AND: PASS0 = low byte, PASS1 = high byte.
- RSH: PASS0 = high byte, PASS1 = low byte.
REQ-009 In PASS0, ALU_SC_IN SHALL be 1 for SUB and 0 otherwise.
REQ-010 In PASS1, ALU_SC_IN SHALL equal the ALU_SC_OUT registered at the end of PASS0.
REQ-011 At the end of PASS0, ALU_OUT SHALL be written to the PASS0 byte of an internal result register. At the end of PASS1, it SHALL be written to the PASS1 byte.
REQ-012 On entry to FIN, the outputs SHALL update as follows:
- RESULT is updated.
- SC_OUT takes the PASS1 ALU_SC_OUT.
- ZERO = (RESULT == 16'h0000), computed from the 16-bit result, not per byte.
REQ-013 DONE SHALL be high exactly in FIN. Latency: START accepted at the edge ending cycle t -> DONE high in cycle t+3.
REQ-014 RESULT, SC_OUT and ZERO SHALL hold until the next operation reaches FIN. They SHALL NOT change during PASS0 or PASS1.
REQ-015 BUSY SHALL be high in PASS0 and PASS1 only.
REQ-016 In IDLE and FIN, ALU_A, ALU_B, ALU_OP and ALU_SC_IN SHALL all be 0.
REQ-017 Illegal OP (6, 7) SHALL take the normal latency. On entry to FIN it SHALL produce RESULT = 0, SC_OUT = 0, ZERO = 1, regardless of ALU outputs.
REQ-018 START accepted in FIN SHALL still let the FIN-cycle DONE pulse complete. The new operation then runs PASS0/PASS1 with no idle gap.

Reset
REQ-019 RESET SHALL take effect asynchronously and force:
- state = IDLE
- RESULT = 0, SC_OUT = 0, ZERO = 0
- BUSY = 0, DONE = 0
- latched operands and latched carry = 0
REQ-020 Reset asserted mid-operation SHALL abort that operation. No DONE pulse SHALL be produced for it. After RESET deasserts, the block SHALL remain in IDLE until a new START.

Verification
REQ-021 ADD, A=16'h00FF, B=16'h0001 -> RESULT 16'h0100, SC_OUT 0, ZERO 0, DONE in cycle t+3.
REQ-022 ADD, A=16'hFFFF, B=16'h0001 -> RESULT 16'h0000, SC_OUT 1, ZERO 1. SUB, A=16'h0100, B=16'h0001 -> RESULT 16'h00FF, SC_OUT 1.
REQ-023 LSH, A=16'h8080 -> RESULT 16'h0100, SC_OUT 1. RSH, A=16'h0101 -> RESULT 16'h0080, SC_OUT 1.
REQ-024 START re-asserted during PASS0 with different A -> ignored, original result produced. START in FIN -> second DONE exactly 3 cycles after the first.
REQ-025 RESET asserted in PASS1 -> immediately BUSY 0, RESULT 0, no DONE. OP=7 -> RESULT 0, SC_OUT 0, ZERO 1 at t+3.
